// File: rtl/ldpc_matrix_row_streamer.sv
// Streams a window of rows from a synchronous matrix ROM onto a valid/ready port.
// A credit check on reads keeps every in-flight ROM word guaranteed a FIFO slot.
//
// state  | meaning
// IDLE   | waiting for req; latches window on acceptance
// ISSUE  | issuing one ROM read per cycle while credit allows
// DRAIN  | all reads issued; waiting for pipe, FIFO and final transfer
// FLUSH  | one-cycle done pulse, then back to IDLE
module ldpc_matrix_row_streamer #(
    parameter int ROW_W      = 256,
    parameter int ROWS       = 128,
    parameter int ADDR_W     = 7,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] start_row,
    input  logic [ADDR_W:0]   row_count,
    output logic              ack,
    input  logic              abort,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ROW_W-1:0]  rom_dout,
    output logic [ROW_W-1:0]  dout,
    output logic              dvalid,
    input  logic              dready,
    output logic [ADDR_W-1:0] drow,
    output logic              dlast,
    output logic              done,
    output logic              busy
);

    localparam int CW    = ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       issue_rem_q, issue_rem_d;
    logic [CW-1:0]       xfer_rem_q, xfer_rem_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [RD_LAT-1:0]   pipe_vld_q, pipe_vld_d;
    logic [RD_LAT-1:0]   pipe_last_q, pipe_last_d;
    logic [ADDR_W-1:0]   pipe_idx_q [RD_LAT];
    logic [ADDR_W-1:0]   pipe_idx_d [RD_LAT];

    logic [ROW_W-1:0]    fifo_data_q [FIFO_DEPTH];
    logic [ROW_W-1:0]    fifo_data_d [FIFO_DEPTH];
    logic [ADDR_W-1:0]   fifo_idx_q  [FIFO_DEPTH];
    logic [ADDR_W-1:0]   fifo_idx_d  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q, fifo_last_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;

    logic [CNT_W-1:0]    in_flight;
    logic                credit;
    logic                issue_ok;
    logic                kill;
    logic                push;
    logic                pop;
    logic                fifo_nempty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + CNT_W'(pipe_vld_q[i]);
        end
    end

    assign fifo_nempty = (fifo_cnt_q != '0);
    assign credit      = (in_flight + fifo_cnt_q) < CNT_W'(FIFO_DEPTH);
    assign kill        = abort && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    assign issue_ok    = (state_q == S_ISSUE) && (issue_rem_q != '0) && credit && !abort;
    assign push        = pipe_vld_q[RD_LAT-1] && !kill;
    assign pop         = fifo_nempty && dready;

    always_comb begin
        state_d     = state_q;
        issue_rem_d = issue_rem_q;
        xfer_rem_d  = xfer_rem_q;
        rd_addr_d   = rd_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pipe_vld_d  = pipe_vld_q;
        pipe_last_d = pipe_last_q;
        pipe_idx_d  = pipe_idx_q;
        fifo_data_d = fifo_data_q;
        fifo_idx_d  = fifo_idx_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;

        // read pipe runs alongside the ROM so data and index arrive together
        pipe_vld_d[0]  = issue_ok;
        pipe_idx_d[0]  = rd_addr_q;
        pipe_last_d[0] = (issue_rem_q == CW'(1));
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_idx_d[i]  = pipe_idx_q[i-1];
            pipe_last_d[i] = pipe_last_q[i-1];
        end

        if (push) begin
            fifo_data_d[wr_ptr_q] = rom_dout;
            fifo_idx_d[wr_ptr_q]  = pipe_idx_q[RD_LAT-1];
            fifo_last_d[wr_ptr_q] = pipe_last_q[RD_LAT-1];
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

        if (pop && (xfer_rem_q != '0)) begin
            xfer_rem_d = xfer_rem_q - CW'(1);
        end

        if (kill) begin
            pipe_vld_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    issue_rem_d = row_count;
                    xfer_rem_d  = row_count;
                    rd_addr_d   = start_row;
                    busy_d      = 1'b1;
                    state_d     = (row_count == '0) ? S_FLUSH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (kill) begin
                    state_d = S_FLUSH;
                end else if (issue_ok) begin
                    issue_rem_d = issue_rem_q - CW'(1);
                    rd_addr_d   = (rd_addr_q == ADDR_W'(ROWS - 1)) ? '0 : rd_addr_q + ADDR_W'(1);
                    if (issue_rem_q == CW'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (kill) begin
                    state_d = S_FLUSH;
                end else if ((in_flight == '0) && !fifo_nempty && (xfer_rem_q == '0)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            issue_rem_q <= '0;
            xfer_rem_q  <= '0;
            rd_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            pipe_idx_q  <= '{default: '0};
            fifo_idx_q  <= '{default: '0};
            fifo_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            issue_rem_q <= issue_rem_d;
            xfer_rem_q  <= xfer_rem_d;
            rd_addr_q   <= rd_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
            pipe_idx_q  <= pipe_idx_d;
            fifo_idx_q  <= fifo_idx_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // row storage needs no reset; it is only observed behind dvalid
    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
    end

    assign ack      = (state_q == S_IDLE) && req;
    assign rom_en   = issue_ok;
    assign rom_addr = rd_addr_q;
    assign dvalid   = fifo_nempty;
    assign dout     = fifo_data_q[rd_ptr_q];
    assign drow     = fifo_idx_q[rd_ptr_q];
    assign dlast    = fifo_nempty && fifo_last_q[rd_ptr_q];
    assign done     = done_q;
    assign busy     = busy_q;

endmodule
